// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared irq mode encoding and default debounce counter width
package gpio_pad_pkg;
    typedef enum logic [1:0] {
        GPIO_IRQ_RISE = 2'b00,
        GPIO_IRQ_FALL = 2'b01,
        GPIO_IRQ_BOTH = 2'b10,
        GPIO_IRQ_HIGH = 2'b11
    } gpio_irq_e;
    localparam int GPIO_DEB_W = 8;
endpackage

// File: rtl/gpio_in_filt.sv
// gpio_in_filt: one channel's pad synchroniser, debounce filter and irq event
module gpio_in_filt
    import gpio_pad_pkg::*;
#(
    parameter int DEB_W = GPIO_DEB_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             c_i,
    input  logic [DEB_W-1:0] deb_cnt_i,
    input  gpio_irq_e        mode_i,
    output logic             filt_o,
    output logic             evt_o
);
    logic             r_s1, r_s2, r_filt;
    logic [DEB_W-1:0] r_cnt;
    logic [DEB_W:0]   w_cnt_inc;
    logic             w_hit, w_f_next;
    // one spare bit keeps cnt+1 from wrapping, so a full counter always commits
    assign w_cnt_inc = {1'b0, r_cnt} + (DEB_W+1)'(1);
    assign w_hit     = (r_s2 != r_filt) && (w_cnt_inc >= {1'b0, deb_cnt_i});
    assign w_f_next  = w_hit ? r_s2 : r_filt;
    assign filt_o    = r_filt;
    assign evt_o     = (mode_i == GPIO_IRQ_HIGH) ? w_f_next :
                       (mode_i == GPIO_IRQ_RISE) ? (w_f_next & ~r_filt) :
                       (mode_i == GPIO_IRQ_FALL) ? (~w_f_next & r_filt) :
                                                   (w_f_next ^ r_filt);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= c_i;
            r_s2   <= r_s1;
            r_filt <= w_f_next;
            r_cnt  <= (r_s2 == r_filt || w_hit) ? '0 : w_cnt_inc[DEB_W-1:0];
        end
    end
endmodule

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: N-channel GPIO pad wiring, filtered read-back and sticky interrupts
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEB_W = GPIO_DEB_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     dir_i,
    input  logic [N-1:0]     dout_i,
    input  logic [N-1:0]     pull_i,
    input  logic [DEB_W-1:0] deb_cnt_i,
    input  logic [2*N-1:0]   mode_i,
    input  logic [N-1:0]     ie_i,
    input  logic [N-1:0]     ic_i,
    output logic [N-1:0]     din_o,
    output logic [N-1:0]     pend_o,
    output logic             irq_o,
    output logic [N-1:0]     pad_i_o,
    output logic [N-1:0]     pad_oen_o,
    output logic [N-1:0]     pad_ren_o,
    input  logic [N-1:0]     pad_c_i
);
    logic [N-1:0] w_filt, w_evt, r_pend;
    assign pad_i_o   = dout_i;
    assign pad_oen_o = dir_i;
    assign pad_ren_o = pull_i;
    assign din_o     = w_filt;
    assign pend_o    = r_pend;
    assign irq_o     = |(r_pend & ie_i);
    for (genvar g = 0; g < N; g++) begin : g_ch
        gpio_in_filt #(.DEB_W(DEB_W)) u_filt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .c_i       (pad_c_i[g]),
            .deb_cnt_i (deb_cnt_i),
            .mode_i    (gpio_irq_e'(mode_i[2*g +: 2])),
            .filt_o    (w_filt[g]),
            .evt_o     (w_evt[g])
        );
    end
    // a new event outranks a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) r_pend <= '0;
        else       r_pend <= (r_pend & ~ic_i) | w_evt;
    end
endmodule
